// File: rtl/tcp_rbcp_bridge_if.sv
// TCP byte-stream and RBCP register-bus signals seen by the bridge.
interface tcp_rbcp_bridge_if;
  logic        TCP_RX_WR;
  logic [7:0]  TCP_RX_DATA;
  logic [15:0] TCP_RX_WC;
  logic        TCP_TX_FULL;
  logic        TCP_TX_WR;
  logic [7:0]  TCP_TX_DATA;
  logic        RBCP_ACT;
  logic [31:0] RBCP_ADDR;
  logic        RBCP_WE;
  logic [7:0]  RBCP_WD;
  logic        RBCP_RE;
  logic        RBCP_ACK;
  logic [7:0]  RBCP_RD;

  modport master (
    input  TCP_RX_WR, TCP_RX_DATA, TCP_TX_FULL,
    input  RBCP_ACK, RBCP_RD,
    output TCP_RX_WC, TCP_TX_WR, TCP_TX_DATA,
    output RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE
  );

  modport slave (
    output TCP_RX_WR, TCP_RX_DATA, TCP_TX_FULL,
    output RBCP_ACK, RBCP_RD,
    input  TCP_RX_WC, TCP_TX_WR, TCP_TX_DATA,
    input  RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE
  );
endinterface

// File: rtl/tcp_rbcp_bridge.sv
// TCP request-frame parser driving RBCP accesses, streaming replies back on TCP TX.
// Define TCP_RBCP_STATS_EN to build the frame/error statistics counters.
module tcp_rbcp_bridge #(
  parameter int RX_AW       = 11,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      TCP_OPEN,
  tcp_rbcp_bridge_if.master         bus,
  output logic                      RX_OVF,
  output logic [15:0]               STAT_FRAMES,
  output logic [15:0]               STAT_ERRORS
);

  localparam int DEPTH = 1 << RX_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TXHDR, S_ACC,
    S_WAIT, S_TXD, S_TXST
  } state_e;

  logic flush;
  assign flush = RST | ~TCP_OPEN;

  // One slot is kept free so the occupancy field saturates at all-ones.
  logic [7:0]       mem_q [DEPTH];
  logic [RX_AW-1:0] wp_q, rp_q, cnt_q, cnt_d;
  logic             ovf_q;
  logic             full, empty, push, pop;
  logic [7:0]       rd_byte;

  assign full    = cnt_q == RX_AW'(DEPTH - 1);
  assign empty   = cnt_q == '0;
  assign push    = bus.TCP_RX_WR & ~full;
  assign rd_byte = mem_q[rp_q];
  assign cnt_d   = cnt_q + RX_AW'(push) - RX_AW'(pop);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= bus.TCP_RX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
      if (bus.TCP_RX_WR && full) ovf_q <= 1'b1;
    end
  end

  state_e      state_q;
  logic        wr_q, to_q, act_q, we_q, re_q, pend_q;
  logic [7:0]  id_q, len_q, wd_q, dat_q, txd_q;
  logic [2:0]  idx_q;
  logic [31:0] addr_q;
  logic [8:0]  rem_q;
  logic [15:0] tmr_q;
  logic        cmd_ok, ld_ok, ack_ok, tmo;
  logic [7:0]  hdr_byte;

  assign cmd_ok = (rd_byte == 8'hC0) || (rd_byte == 8'h80);
  assign ld_ok  = ~pend_q | ~bus.TCP_TX_FULL;
  // The pulse cycle has tmr_q == 0, so an ACK there is ignored.
  assign ack_ok = bus.RBCP_ACK && (tmr_q != 16'd0);
  assign tmo    = ~ack_ok && (tmr_q == 16'(TIMEOUT_CYC));

  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      case (state_q)
        S_IDLE, S_HDR: pop = 1'b1;
        S_ACC:         pop = wr_q;
        default:       pop = 1'b0;
      endcase
    end
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q)
      3'd0: hdr_byte = {1'b1, wr_q, 6'b001000};
      3'd1: hdr_byte = id_q;
      3'd2: hdr_byte = len_q;
      3'd3: hdr_byte = addr_q[31:24];
      3'd4: hdr_byte = addr_q[23:16];
      3'd5: hdr_byte = addr_q[15:8];
      3'd6: hdr_byte = addr_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      to_q    <= 1'b0;
      act_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      pend_q  <= 1'b0;
      id_q    <= '0;
      len_q   <= '0;
      wd_q    <= '0;
      dat_q   <= '0;
      txd_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      tmr_q   <= '0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      if (pend_q && !bus.TCP_TX_FULL) pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty && cmd_ok) begin
            wr_q    <= rd_byte[6];
            to_q    <= 1'b0;
            idx_q   <= '0;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (!empty) begin
            idx_q <= idx_q + 3'd1;
            case (idx_q)
              3'd0: id_q <= rd_byte;
              3'd1: begin
                len_q <= rd_byte;
                rem_q <= (rd_byte == 8'd0) ? 9'd256
                                           : {1'b0, rd_byte};
              end
              default: addr_q <= {addr_q[23:0], rd_byte};
            endcase
            if (idx_q == 3'd5) begin
              idx_q   <= '0;
              act_q   <= 1'b1;
              state_q <= S_TXHDR;
            end
          end
        end
        S_TXHDR: begin
          if (ld_ok) begin
            txd_q  <= hdr_byte;
            pend_q <= 1'b1;
            idx_q  <= idx_q + 3'd1;
            if (idx_q == 3'd6) state_q <= S_ACC;
          end
        end
        S_ACC: begin
          if (!wr_q) begin
            re_q    <= 1'b1;
            tmr_q   <= '0;
            state_q <= S_WAIT;
          end else if (!empty) begin
            wd_q    <= rd_byte;
            we_q    <= 1'b1;
            tmr_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_ok) begin
            dat_q   <= wr_q ? wd_q : bus.RBCP_RD;
            state_q <= S_TXD;
          end else if (tmo) begin
            dat_q   <= wr_q ? wd_q : 8'h00;
            to_q    <= 1'b1;
            state_q <= S_TXD;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        S_TXD: begin
          if (ld_ok) begin
            txd_q   <= dat_q;
            pend_q  <= 1'b1;
            addr_q  <= addr_q + 32'd1;
            rem_q   <= rem_q - 9'd1;
            state_q <= (rem_q == 9'd1) ? S_TXST : S_ACC;
          end
        end
        S_TXST: begin
          if (ld_ok) begin
            txd_q   <= {7'b0, to_q};
            pend_q  <= 1'b1;
            act_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.TCP_RX_WC   = {{(16 - RX_AW){1'b1}}, cnt_q};
  assign bus.TCP_TX_WR   = pend_q & ~bus.TCP_TX_FULL;
  assign bus.TCP_TX_DATA = txd_q;
  assign bus.RBCP_ACT    = act_q;
  assign bus.RBCP_ADDR   = addr_q;
  assign bus.RBCP_WE     = we_q;
  assign bus.RBCP_WD     = wd_q;
  assign bus.RBCP_RE     = re_q;
  assign RX_OVF          = ovf_q;

`ifdef TCP_RBCP_STATS_EN
  logic        err_inc, frm_inc;
  logic [15:0] frm_q, err_q;

  assign err_inc = ~flush &
    (((state_q == S_IDLE) & ~empty & ~cmd_ok) |
     ((state_q == S_WAIT) & tmo));
  assign frm_inc = ~flush & (state_q == S_TXST) & ld_ok;

  // Counters survive a connection close; only RST clears them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frm_q <= '0;
      err_q <= '0;
    end else begin
      if (frm_inc && frm_q != 16'hFFFF) frm_q <= frm_q + 16'd1;
      if (err_inc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end

  assign STAT_FRAMES = frm_q;
  assign STAT_ERRORS = err_q;
`else
  assign STAT_FRAMES = 16'h0000;
  assign STAT_ERRORS = 16'h0000;
`endif

endmodule

// File: tb/tb_tcp_rbcp_bridge.sv
// Directed bench for tcp_rbcp_bridge: write/read frames, timeout,
// TX back-pressure, resync, RX overflow and flush.
module tb_tcp_rbcp_bridge;

`ifdef TCP_RBCP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        open;
  logic        ovf;
  logic [15:0] st_frm, st_err;

  tcp_rbcp_bridge_if bus ();

  tcp_rbcp_bridge #(.RX_AW(8), .TIMEOUT_CYC(20)) dut (
    .CLK         (clk),
    .RST         (rst),
    .TCP_OPEN    (open),
    .bus         (bus),
    .RX_OVF      (ovf),
    .STAT_FRAMES (st_frm),
    .STAT_ERRORS (st_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int ack_dly = 1;
  int skip_n  = 0;
  int acc_n   = 0;
  int cd      = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  logic [31:0] rlog_a[$];

  always @(posedge clk) begin
    if (bus.TCP_TX_WR === 1'b1) tx_q.push_back(bus.TCP_TX_DATA);
    if (bus.TCP_TX_WR === 1'b1 && bus.TCP_TX_FULL === 1'b1) viol++;
  end

  // Register responder: acks ack_dly negedges after a pulse, skips access skip_n.
  always @(negedge clk) begin
    bus.RBCP_ACK = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) bus.RBCP_ACK = 1'b1;
    end
    if (bus.RBCP_WE === 1'b1 || bus.RBCP_RE === 1'b1) begin
      acc_n++;
      if (bus.RBCP_WE === 1'b1) begin
        wlog_a.push_back(bus.RBCP_ADDR);
        wlog_d.push_back(bus.RBCP_WD);
      end else begin
        rlog_a.push_back(bus.RBCP_ADDR);
      end
      if (acc_n != skip_n) begin
        if (ack_dly == 0) bus.RBCP_ACK = 1'b1;
        else cd = ack_dly;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx();
    foreach (rx_q[i]) begin
      @(negedge clk);
      bus.TCP_RX_WR   = 1'b1;
      bus.TCP_RX_DATA = rx_q[i];
      @(negedge clk);
      bus.TCP_RX_WR   = 1'b0;
    end
    rx_q.delete();
  endtask

  task automatic check_reply(input string tag);
    int n = 0;
    while (tx_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_len"}, 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < tx_q.size())
        chk($sformatf("%s_b%0d", tag, i), 32'(tx_q[i]), 32'(exp_q[i]));
    tx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int sz;
    int n;
    rst = 1'b1;
    open = 1'b1;
    bus.TCP_RX_WR   = 1'b0;
    bus.TCP_RX_DATA = 8'h00;
    bus.TCP_TX_FULL = 1'b0;
    bus.RBCP_RD     = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txwr", 32'(bus.TCP_TX_WR), 32'h0);
    chk("rst_act",  32'(bus.RBCP_ACT), 32'h0);
    chk("rst_wc",   32'(bus.TCP_RX_WC), 32'hFF00);
    chk("rst_addr", bus.RBCP_ADDR, 32'h0);
    chk("rst_ovf",  32'(ovf), 32'h0);
    chk("rst_frm",  32'(st_frm), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write two bytes at 0x10, ACK two cycles after each pulse
    ack_dly = 2;
    rx_q = '{8'hC0, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB};
    send_rx();
    exp_q = '{8'hC8, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h10,
              8'hAA, 8'hBB, 8'h00};
    check_reply("wr");
    chk("wr_cnt", 32'(wlog_a.size()), 32'd2);
    chk("wr_a0", wlog_a[0], 32'h10);
    chk("wr_d0", 32'(wlog_d[0]), 32'hAA);
    chk("wr_a1", wlog_a[1], 32'h11);
    chk("wr_d1", 32'(wlog_d[1]), 32'hBB);
    chk("wr_act_off", 32'(bus.RBCP_ACT), 32'h0);

    // Read at the top of the address space, address wraps afterwards
    ack_dly = 1;
    bus.RBCP_RD = 8'h5A;
    rx_q = '{8'h80, 8'h07, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_rx();
    exp_q = '{8'h88, 8'h07, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h00};
    check_reply("rdw");
    chk("rdw_re_a", rlog_a[0], 32'hFFFF_FFFF);
    chk("rdw_wrap", bus.RBCP_ADDR, 32'h0);

    // Three-byte read, middle byte (access #5) never acknowledged
    ack_dly = 2;
    skip_n  = 5;
    bus.RBCP_RD = 8'h33;
    rx_q = '{8'h80, 8'h08, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00};
    send_rx();
    exp_q = '{8'h88, 8'h08, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h33, 8'h00, 8'h33, 8'h01};
    check_reply("tmo");
    chk("tmo_re_a1", rlog_a[2], 32'h101);
    chk("tmo_re_a2", rlog_a[3], 32'h102);
    chk("tmo_err", 32'(st_err), STATS ? 32'd1 : 32'd0);
    skip_n = 0;

    // TX_FULL held 20 cycles in the middle of a 4-byte read reply
    ack_dly = 1;
    bus.RBCP_RD = 8'h77;
    rx_q = '{8'h80, 8'h09, 8'h04, 8'h00, 8'h00, 8'h00, 8'h20};
    send_rx();
    n = 0;
    while (tx_q.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    bus.TCP_TX_FULL = 1'b1;
    sz = tx_q.size();
    repeat (20) @(negedge clk);
    chk("full_hold", 32'(tx_q.size()), 32'(sz));
    chk("full_viol", 32'(viol), 32'd0);
    bus.TCP_TX_FULL = 1'b0;
    exp_q = '{8'h88, 8'h09, 8'h04, 8'h00, 8'h00, 8'h00, 8'h20,
              8'h77, 8'h77, 8'h77, 8'h77, 8'h00};
    check_reply("full");

    // ACK in the pulse cycle itself must be ignored -> timeout
    ack_dly = 0;
    bus.RBCP_RD = 8'h99;
    rx_q = '{8'h80, 8'h0D, 8'h01, 8'h00, 8'h00, 8'h00, 8'h60};
    send_rx();
    exp_q = '{8'h88, 8'h0D, 8'h01, 8'h00, 8'h00, 8'h00, 8'h60, 8'h00, 8'h01};
    check_reply("early");
    ack_dly = 1;

    // Two junk bytes then a valid read: resync
    bus.RBCP_RD = 8'h11;
    rx_q = '{8'h12, 8'h34, 8'h80, 8'h0A, 8'h01,
             8'h00, 8'h00, 8'h00, 8'h30};
    send_rx();
    exp_q = '{8'h88, 8'h0A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h11, 8'h00};
    check_reply("junk");
    chk("junk_err", 32'(st_err), STATS ? 32'd4 : 32'd0);
    chk("junk_frm", 32'(st_frm), STATS ? 32'd6 : 32'd0);

    // RX overflow with TX blocked, then TCP_OPEN low flush
    bus.TCP_TX_FULL = 1'b1;
    rx_q = '{8'h80, 8'h0B, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40};
    send_rx();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.TCP_RX_WR   = 1'b1;
      bus.TCP_RX_DATA = 8'(i);
    end
    @(negedge clk);
    bus.TCP_RX_WR = 1'b0;
    chk("ovf_wc100", 32'(bus.TCP_RX_WC), 32'hFF64);
    chk("ovf_pre", 32'(ovf), 32'h0);
    for (int i = 0; i < 157; i++) begin
      @(negedge clk);
      bus.TCP_RX_WR   = 1'b1;
      bus.TCP_RX_DATA = 8'(i);
    end
    @(negedge clk);
    bus.TCP_RX_WR = 1'b0;
    chk("ovf_wcfull", 32'(bus.TCP_RX_WC), 32'hFFFF);
    chk("ovf_flag", 32'(ovf), 32'h1);
    chk("ovf_act", 32'(bus.RBCP_ACT), 32'h1);
    chk("ovf_notx", 32'(tx_q.size()), 32'd0);
    open = 1'b0;
    @(negedge clk);
    bus.TCP_TX_FULL = 1'b0;
    @(negedge clk);
    chk("cls_wc", 32'(bus.TCP_RX_WC), 32'hFF00);
    chk("cls_ovf", 32'(ovf), 32'h0);
    chk("cls_act", 32'(bus.RBCP_ACT), 32'h0);
    chk("cls_txwr", 32'(bus.TCP_TX_WR), 32'h0);
    chk("cls_frm", 32'(st_frm), STATS ? 32'd6 : 32'd0);
    open = 1'b1;
    repeat (3) @(negedge clk);
    chk("cls_notx", 32'(tx_q.size()), 32'd0);

    // Service resumes after reopen
    bus.RBCP_RD = 8'h42;
    rx_q = '{8'h80, 8'h0E, 8'h02, 8'h00, 8'h00, 8'h00, 8'h70};
    send_rx();
    exp_q = '{8'h88, 8'h0E, 8'h02, 8'h00, 8'h00, 8'h00, 8'h70,
              8'h42, 8'h42, 8'h00};
    check_reply("reopen");
    chk("reopen_frm", 32'(st_frm), STATS ? 32'd7 : 32'd0);
    chk("reopen_err", 32'(st_err), STATS ? 32'd4 : 32'd0);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_frm", 32'(st_frm), 32'h0);
    chk("rst2_err", 32'(st_err), 32'h0);
    chk("rst2_addr", bus.RBCP_ADDR, 32'h0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
